// File: rtl/task_graph_sequencer.sv
// Streams an NxN weight matrix row-major to task_mapper after a root pulse; first entry 2 cycles after start, GAP cycles apart.
// Holds entry and indices stable while task_ready is low; all outputs registered, no ready-to-valid path.
module task_graph_sequencer #(
    parameter int N   = 3,
    parameter int W   = 32,
    parameter int GAP = 2
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 cfg_we,
    input  logic [$clog2(N)-1:0] cfg_row,
    input  logic [$clog2(N)-1:0] cfg_col,
    input  logic [W-1:0]         cfg_wdata,
    output logic                 cfg_err,
    input  logic                 start,
    input  logic                 abort,
    output logic                 root_task,
    output logic [W-1:0]         task_array,
    output logic                 task_valid,
    input  logic                 task_ready,
    output logic [$clog2(N)-1:0] row_idx,
    output logic [$clog2(N)-1:0] col_idx,
    output logic                 busy,
    output logic                 done
);
    localparam int IW = $clog2(N);
    localparam int CW = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [IW-1:0] LAST     = IW'(N - 1);
    localparam logic [CW-1:0] GAP_LOAD = (GAP > 1) ? CW'(GAP - 2) : '0;

    typedef enum logic [2:0] {S_IDLE, S_ROOT, S_SEND, S_GAPW, S_DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    mem_q [N][N];
    logic [IW-1:0]   row_q, col_q;
    logic [IW-1:0]   row_d, col_d;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    arr_q;
    logic            vld_q, root_q, busy_q, done_q, err_q;
    logic            hs, last_entry, wr_bad, wr_ok;

    always_comb begin
        hs         = (state_q == S_SEND) && task_ready;
        last_entry = (row_q == LAST) && (col_q == LAST);
        col_d      = (col_q == LAST) ? '0 : col_q + 1'b1;
        row_d      = (col_q == LAST) ? row_q + 1'b1 : row_q;
        // Writes outside IDLE or beyond the matrix are dropped and flagged.
        wr_bad     = cfg_we && ((state_q != S_IDLE) || (cfg_row > LAST) || (cfg_col > LAST));
        wr_ok      = cfg_we && !wr_bad;
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mem_q[r][c] <= '0;
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            arr_q   <= '0;
            vld_q   <= 1'b0;
            root_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q  <= wr_bad;
            root_q <= 1'b0;
            done_q <= 1'b0;
            if (wr_ok)
                mem_q[cfg_row][cfg_col] <= cfg_wdata;

            if (abort) begin
                state_q <= S_IDLE;
                row_q   <= '0;
                col_q   <= '0;
                cnt_q   <= '0;
                arr_q   <= '0;
                vld_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_ROOT;
                            root_q  <= 1'b1;
                            busy_q  <= 1'b1;
                            row_q   <= '0;
                            col_q   <= '0;
                        end
                    end
                    S_ROOT: begin
                        // mem_q already holds a write that landed with start.
                        state_q <= S_SEND;
                        vld_q   <= 1'b1;
                        arr_q   <= mem_q[row_q][col_q];
                    end
                    S_SEND: begin
                        if (hs) begin
                            if (last_entry) begin
                                state_q <= S_DONE;
                                vld_q   <= 1'b0;
                                arr_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                row_q   <= '0;
                                col_q   <= '0;
                            end else begin
                                row_q <= row_d;
                                col_q <= col_d;
                                if (GAP > 1) begin
                                    state_q <= S_GAPW;
                                    vld_q   <= 1'b0;
                                    arr_q   <= '0;
                                    cnt_q   <= GAP_LOAD;
                                end else begin
                                    arr_q <= mem_q[row_d][col_d];
                                end
                            end
                        end
                    end
                    S_GAPW: begin
                        if (cnt_q == '0) begin
                            state_q <= S_SEND;
                            vld_q   <= 1'b1;
                            arr_q   <= mem_q[row_q][col_q];
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg_err    = err_q;
    assign root_task  = root_q;
    assign task_array = arr_q;
    assign task_valid = vld_q;
    assign row_idx    = row_q;
    assign col_idx    = col_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_task_graph_sequencer.sv
// Directed bench for task_graph_sequencer: one GAP=2 instance for the main flows, one GAP=1 instance for back-to-back streaming.
module tb_task_graph_sequencer;
    localparam int N  = 3;
    localparam int W  = 32;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_b;
    logic          cfg_we, cfg_err, start, abort, root_task, task_valid, task_ready, busy, done;
    logic [IW-1:0] cfg_row, cfg_col, row_idx, col_idx;
    logic [W-1:0]  cfg_wdata, task_array;

    logic          cfg_we1, cfg_err1, start1, abort1, root1, valid1, ready1, busy1, done1;
    logic [IW-1:0] cfg_row1, cfg_col1, row1, col1;
    logic [W-1:0]  cfg_wdata1, array1;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_m [9];

    task_graph_sequencer #(.N(N), .W(W), .GAP(2)) dut (
        .clk(clk), .rst_b(rst_b), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
        .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .start(start), .abort(abort),
        .root_task(root_task), .task_array(task_array), .task_valid(task_valid),
        .task_ready(task_ready), .row_idx(row_idx), .col_idx(col_idx), .busy(busy), .done(done)
    );

    task_graph_sequencer #(.N(N), .W(W), .GAP(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .cfg_we(cfg_we1), .cfg_row(cfg_row1), .cfg_col(cfg_col1),
        .cfg_wdata(cfg_wdata1), .cfg_err(cfg_err1), .start(start1), .abort(abort1),
        .root_task(root1), .task_array(array1), .task_valid(valid1),
        .task_ready(ready1), .row_idx(row1), .col_idx(col1), .busy(busy1), .done(done1)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input int c, input logic [W-1:0] d);
        cfg_we    = 1'b1;
        cfg_row   = IW'(r);
        cfg_col   = IW'(c);
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        check_vec("cfg_ok", 64'(cfg_err), 64'd0);
    endtask

    // Runs one full sequence on the GAP=2 instance against exp_m, optionally stalling entry stall_k.
    task automatic run_seq(input int stall_k, input int stall_n);
        int cyc;
        int w;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        check_vec("root", 64'(root_task), 64'd1);
        check_vec("busy_root", 64'(busy), 64'd1);
        check_vec("root_idx", 64'({row_idx, col_idx}), 64'd0);
        tick();
        cyc++;
        for (int k = 0; k < 9; k++) begin
            w = 0;
            while (!task_valid && w < 8) begin
                check_vec("gap_arr", 64'(task_array), 64'd0);
                tick();
                cyc++;
                w++;
            end
            check_vec("valid", 64'(task_valid), 64'd1);
            check_vec("arr", 64'(task_array), 64'(exp_m[k]));
            check_vec("row", 64'(row_idx), 64'(k / 3));
            check_vec("col", 64'(col_idx), 64'(k % 3));
            check_vec("entry_cyc", 64'(cyc), 64'(2 + 2 * k + ((k > stall_k) ? stall_n : 0)));
            if (k == stall_k) begin
                task_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    cyc++;
                    check_vec("hold_vld", 64'(task_valid), 64'd1);
                    check_vec("hold_arr", 64'(task_array), 64'(exp_m[k]));
                    check_vec("hold_idx", 64'({row_idx, col_idx}), 64'((k / 3) * 4 + (k % 3)));
                end
                task_ready = 1'b1;
            end
            tick();
            cyc++;
        end
        check_vec("done", 64'(done), 64'd1);
        check_vec("busy_done", 64'(busy), 64'd0);
        check_vec("done_cyc", 64'(cyc), 64'(19 + ((stall_k < 9) ? stall_n : 0)));
        tick();
        check_vec("done_clr", 64'(done), 64'd0);
    endtask

    initial begin
        int w;
        int seen;
        int c;
        logic [W-1:0] vals [9];
        vals = '{32'd0, 32'd5, 32'd0, 32'd5, 32'd0, 32'd6, 32'd0, 32'd6, 32'd0};

        rst_b = 1'b1;
        cfg_we = 1'b0; cfg_row = '0; cfg_col = '0; cfg_wdata = '0;
        start = 1'b0; abort = 1'b0; task_ready = 1'b1;
        cfg_we1 = 1'b0; cfg_row1 = '0; cfg_col1 = '0; cfg_wdata1 = '0;
        start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
        repeat (3) tick();
        rst_b = 1'b0;
        repeat (5) tick();

        check_vec("rst_root", 64'(root_task), 64'd0);
        check_vec("rst_valid", 64'(task_valid), 64'd0);
        check_vec("rst_arr", 64'(task_array), 64'd0);
        check_vec("rst_busy", 64'(busy), 64'd0);
        check_vec("rst_done", 64'(done), 64'd0);
        check_vec("rst_err", 64'(cfg_err), 64'd0);
        check_vec("rst_idx", 64'({row_idx, col_idx}), 64'd0);
        check_vec("rst1_valid", 64'(valid1), 64'd0);

        for (int k = 0; k < 9; k++) exp_m[k] = '0;
        run_seq(99, 0);

        for (int k = 0; k < 9; k++) begin
            wr(k / 3, k % 3, vals[k]);
            exp_m[k] = vals[k];
        end
        run_seq(99, 0);
        run_seq(5, 3);

        // start and abort together in IDLE stays idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_vec("sa_root", 64'(root_task), 64'd0);
        check_vec("sa_busy", 64'(busy), 64'd0);

        // abort while entry (1,0) is presented, ready high
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!(task_valid && row_idx == 2'd1 && col_idx == 2'd0) && w < 20) begin
            tick();
            w++;
        end
        check_vec("ab_found", 64'(task_valid), 64'd1);
        check_vec("ab_arr", 64'(task_array), 64'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_vec("ab_valid", 64'(task_valid), 64'd0);
        check_vec("ab_busy", 64'(busy), 64'd0);
        check_vec("ab_arr0", 64'(task_array), 64'd0);
        check_vec("ab_idx", 64'({row_idx, col_idx}), 64'd0);
        seen = 0;
        repeat (25) begin
            if (done) seen = 1;
            tick();
        end
        check_vec("ab_no_done", 64'(seen), 64'd0);
        run_seq(99, 0);

        // write while busy is rejected
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_we = 1'b1; cfg_row = 2'd0; cfg_col = 2'd1; cfg_wdata = 32'd99;
        tick();
        cfg_we = 1'b0;
        check_vec("err_busy", 64'(cfg_err), 64'd1);
        tick();
        check_vec("err_pulse", 64'(cfg_err), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // out-of-range row is rejected
        cfg_we = 1'b1; cfg_row = 2'd3; cfg_col = 2'd0; cfg_wdata = 32'd77;
        tick();
        cfg_we = 1'b0;
        check_vec("err_range", 64'(cfg_err), 64'd1);
        tick();
        check_vec("err_range_clr", 64'(cfg_err), 64'd0);
        run_seq(99, 0);

        // GAP=1: same-cycle write and start, entries on consecutive cycles
        cfg_we1 = 1'b1; cfg_row1 = 2'd0; cfg_col1 = 2'd0; cfg_wdata1 = 32'd7;
        start1 = 1'b1;
        tick();
        cfg_we1 = 1'b0; start1 = 1'b0;
        c = 1;
        check_vec("g1_err", 64'(cfg_err1), 64'd0);
        check_vec("g1_root", 64'(root1), 64'd1);
        tick();
        c++;
        for (int k = 0; k < 9; k++) begin
            check_vec("g1_valid", 64'(valid1), 64'd1);
            check_vec("g1_arr", 64'(array1), (k == 0) ? 64'd7 : 64'd0);
            check_vec("g1_idx", 64'({row1, col1}), 64'((k / 3) * 4 + (k % 3)));
            tick();
            c++;
        end
        check_vec("g1_done", 64'(done1), 64'd1);
        check_vec("g1_busy", 64'(busy1), 64'd0);
        check_vec("g1_done_cyc", 64'(c), 64'd11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
